// File: rtl/pcie_pclk_rate_ctrl_if.sv
// Request/status bundle between the PCIe integration and the PIPE pclk rate controller.
interface pcie_pclk_rate_ctrl_if #(parameter int LANES = 8);
  logic [LANES-1:0] lane_sel_in;
  logic [LANES-1:0] lane_mask;
  logic             mmcm_locked;
  logic             mismatch_clr;
  logic             pclk_sel;
  logic             bufg_s0;
  logic             bufg_s1;
  logic             busy;
  logic             switch_done;
  logic [15:0]      switch_count;
  logic             mismatch_err;

  modport master (
    output lane_sel_in, lane_mask, mmcm_locked, mismatch_clr,
    input  pclk_sel, bufg_s0, bufg_s1, busy, switch_done, switch_count, mismatch_err
  );

  modport slave (
    input  lane_sel_in, lane_mask, mmcm_locked, mismatch_clr,
    output pclk_sel, bufg_s0, bufg_s1, busy, switch_done, switch_count, mismatch_err
  );
endinterface

// File: rtl/pcie_pclk_rate_ctrl.sv
// PIPE pclk rate controller: per-lane request sync, qualification, break-before-make BUFGCTRL drive.
// Optional PCLK_RATE_STATS_EN builds switch_count and the lane-mismatch detector.
module pcie_pclk_rate_lane_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], d_i};

  assign q_o = sync_q[STAGES-1];
endmodule

module pcie_pclk_rate_ctrl #(
  parameter int LANES           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int STABLE_CYCLES   = 16,
  parameter int GAP_CYCLES      = 4,
  parameter int MISMATCH_CYCLES = 1024
) (
  input logic                  sys_clk,
  input logic                  sys_reset_n,
  pcie_pclk_rate_ctrl_if.slave bus
);
  typedef enum logic [1:0] {STEADY, QUAL, GAP} state_t;

  logic [LANES-1:0] s;
  state_t           state_q;
  logic [15:0]      cnt_q;
  logic             new_sel_q, pclk_sel_q, bufg_s0_q, bufg_s1_q, busy_q, switch_done_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    pcie_pclk_rate_lane_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (sys_clk),
      .rst_n (sys_reset_n),
      .d_i   (bus.lane_sel_in[g]),
      .q_o   (s[g])
    );
  end

  // Masked-off lanes count as agreeing with either rate.
  logic mask_any, all_hi, all_lo, mixed, target_valid, target, commit;
  assign mask_any     = |bus.lane_mask;
  assign all_hi       = &(s | ~bus.lane_mask);
  assign all_lo       = &(~s | ~bus.lane_mask);
  assign mixed        = mask_any && !all_hi && !all_lo;
  assign target_valid = mask_any && (all_hi || all_lo);
  assign target       = all_hi;
  assign commit       = bus.mmcm_locked && (state_q == GAP) && (cnt_q == 16'(GAP_CYCLES - 1));

  always_ff @(posedge sys_clk or negedge sys_reset_n)
    if (!sys_reset_n) begin
      state_q       <= STEADY;
      cnt_q         <= '0;
      new_sel_q     <= 1'b0;
      pclk_sel_q    <= 1'b0;
      bufg_s0_q     <= 1'b1;
      bufg_s1_q     <= 1'b0;
      busy_q        <= 1'b0;
      switch_done_q <= 1'b0;
    end else begin
      switch_done_q <= 1'b0;
      if (!bus.mmcm_locked) begin
        // Unlocked MMCM: fall back to the 125 MHz leg, abandoning any switch in flight.
        state_q    <= STEADY;
        cnt_q      <= '0;
        pclk_sel_q <= 1'b0;
        bufg_s0_q  <= 1'b1;
        bufg_s1_q  <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        case (state_q)
          STEADY:
            if (target_valid && target != pclk_sel_q) begin
              state_q <= QUAL;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
            end
          QUAL:
            if (!target_valid || target == pclk_sel_q) begin
              state_q <= STEADY;
              busy_q  <= 1'b0;
            end else if (cnt_q == 16'(STABLE_CYCLES - 1)) begin
              state_q   <= GAP;
              new_sel_q <= target;
              bufg_s0_q <= 1'b0;
              bufg_s1_q <= 1'b0;
              cnt_q     <= '0;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          GAP:
            if (commit) begin
              state_q       <= STEADY;
              busy_q        <= 1'b0;
              pclk_sel_q    <= new_sel_q;
              bufg_s0_q     <= ~new_sel_q;
              bufg_s1_q     <= new_sel_q;
              switch_done_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          default: state_q <= STEADY;
        endcase
      end
    end

  assign bus.pclk_sel    = pclk_sel_q;
  assign bus.bufg_s0     = bufg_s0_q;
  assign bus.bufg_s1     = bufg_s1_q;
  assign bus.busy        = busy_q;
  assign bus.switch_done = switch_done_q;

`ifdef PCLK_RATE_STATS_EN
  localparam int MMW = $clog2(MISMATCH_CYCLES) + 1;

  logic [15:0]    switch_count_q, switch_count_d;
  logic [MMW-1:0] mm_cnt_q;
  logic           mismatch_err_q;

  assign switch_count_d = (commit && switch_count_q != 16'hFFFF) ? switch_count_q + 16'd1
                                                                  : switch_count_q;

  // mm_cnt saturates so a persistent disagreement keeps re-asserting the flag over a clear.
  always_ff @(posedge sys_clk or negedge sys_reset_n)
    if (!sys_reset_n) begin
      switch_count_q <= '0;
      mm_cnt_q       <= '0;
      mismatch_err_q <= 1'b0;
    end else begin
      switch_count_q <= switch_count_d;
      if (!mixed)                                   mm_cnt_q <= '0;
      else if (mm_cnt_q != MMW'(MISMATCH_CYCLES - 1)) mm_cnt_q <= mm_cnt_q + 1'b1;
      if (mixed && mm_cnt_q == MMW'(MISMATCH_CYCLES - 1)) mismatch_err_q <= 1'b1;
      else if (bus.mismatch_clr)                          mismatch_err_q <= 1'b0;
    end

  assign bus.switch_count = switch_count_q;
  assign bus.mismatch_err = mismatch_err_q;
`else
  logic unused_stats;
  assign unused_stats     = ^{bus.mismatch_clr, mixed};
  assign bus.switch_count = '0;
  assign bus.mismatch_err = 1'b0;
`endif
endmodule

// File: tb/tb_pcie_pclk_rate_ctrl.sv
// Directed bench for pcie_pclk_rate_ctrl: LANES=8, SYNC=2, STABLE=4, GAP=2, MISMATCH=8.
module tb_pcie_pclk_rate_ctrl;
`ifdef PCLK_RATE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk, rst_n;
  int   total, passed, failed, done_seen;

  pcie_pclk_rate_ctrl_if #(.LANES(8)) bus ();

  pcie_pclk_rate_ctrl #(
    .LANES(8), .SYNC_STAGES(2), .STABLE_CYCLES(4), .GAP_CYCLES(2), .MISMATCH_CYCLES(8)
  ) dut (
    .sys_clk     (clk),
    .sys_reset_n (rst_n),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.switch_done === 1'b1) done_seen++;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cexp(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  initial begin
    total = 0; passed = 0; failed = 0; done_seen = 0;
    rst_n = 1'b0;
    bus.lane_sel_in  = 8'h00;
    bus.lane_mask    = 8'hFF;
    bus.mmcm_locked  = 1'b1;
    bus.mismatch_clr = 1'b0;
    #20;
    chk("rst_pclk_sel", 32'(bus.pclk_sel), 0);
    chk("rst_bufg_s0", 32'(bus.bufg_s0), 1);
    chk("rst_bufg_s1", 32'(bus.bufg_s1), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_switch_done", 32'(bus.switch_done), 0);
    chk("rst_switch_count", 32'(bus.switch_count), 0);
    chk("rst_mismatch_err", 32'(bus.mismatch_err), 0);
    rst_n = 1'b1;
    step(2);

    // Glitch: synced request high for edges 3..5 only, QUAL aborts at edge 6
    bus.lane_sel_in = 8'hFF;
    step(3);
    chk("glitch_qual_entered", 32'(bus.busy), 1);
    bus.lane_sel_in = 8'h00;
    step(3);
    chk("glitch_aborted_busy", 32'(bus.busy), 0);
    step(4);
    chk("glitch_bufg_s0", 32'(bus.bufg_s0), 1);
    chk("glitch_pclk_sel", 32'(bus.pclk_sel), 0);
    chk("glitch_no_done", 32'(done_seen), 0);
    chk("glitch_count", 32'(bus.switch_count), 0);

    // Upswitch: s0 falls at edge 7, s1 rises at edge 9
    bus.lane_sel_in = 8'hFF;
    step(6);
    chk("up_e6_s0", 32'(bus.bufg_s0), 1);
    chk("up_e6_busy", 32'(bus.busy), 1);
    step(1);
    chk("up_e7_s0_low", 32'(bus.bufg_s0), 0);
    chk("up_e7_s1_low", 32'(bus.bufg_s1), 0);
    step(1);
    chk("up_e8_s1_low", 32'(bus.bufg_s1), 0);
    chk("up_e8_no_done", 32'(bus.switch_done), 0);
    step(1);
    chk("up_e9_s1", 32'(bus.bufg_s1), 1);
    chk("up_e9_s0", 32'(bus.bufg_s0), 0);
    chk("up_e9_done", 32'(bus.switch_done), 1);
    chk("up_e9_pclk_sel", 32'(bus.pclk_sel), 1);
    chk("up_e9_busy", 32'(bus.busy), 0);
    chk("up_e9_count", 32'(bus.switch_count), cexp(1));
    step(1);
    chk("up_e10_done_pulse", 32'(bus.switch_done), 0);

    // Downswitch, then masked-width upswitch with lanes 4-7 low
    bus.lane_sel_in = 8'h00;
    step(10);
    chk("down_pclk_sel", 32'(bus.pclk_sel), 0);
    chk("down_bufg_s0", 32'(bus.bufg_s0), 1);
    bus.lane_mask   = 8'h0F;
    bus.lane_sel_in = 8'h0F;
    step(10);
    chk("mask_pclk_sel", 32'(bus.pclk_sel), 1);
    chk("mask_bufg_s1", 32'(bus.bufg_s1), 1);
    chk("mask_done_total", 32'(done_seen), 3);
    chk("mask_count", 32'(bus.switch_count), cexp(3));

    // Mismatch: mixed from edge 1 (0x0F then 0xF0 under full mask), flag sets at edge 8
    bus.lane_mask   = 8'hFF;
    bus.lane_sel_in = 8'hF0;
    step(7);
    chk("mm_e7_not_yet", 32'(bus.mismatch_err), 0);
    step(1);
    chk("mm_e8_set", 32'(bus.mismatch_err), cexp(1));
    bus.mismatch_clr = 1'b1;
    step(1);
    bus.mismatch_clr = 1'b0;
    chk("mm_clr_while_mixed", 32'(bus.mismatch_err), cexp(1));
    chk("mm_pclk_held", 32'(bus.pclk_sel), 1);
    chk("mm_not_busy", 32'(bus.busy), 0);
    bus.lane_sel_in = 8'hFF;
    step(4);
    chk("mm_agree_still_set", 32'(bus.mismatch_err), cexp(1));
    bus.mismatch_clr = 1'b1;
    step(1);
    bus.mismatch_clr = 1'b0;
    chk("mm_cleared", 32'(bus.mismatch_err), 0);
    chk("mm_no_switch", 32'(done_seen), 3);

    // Lock loss in GAP of an upswitch, then requalification after relock
    bus.lane_sel_in = 8'h00;
    step(10);
    chk("ll_pre_pclk_sel", 32'(bus.pclk_sel), 0);
    bus.lane_sel_in = 8'hFF;
    step(7);
    chk("ll_in_gap", 32'({bus.bufg_s0, bus.bufg_s1}), 0);
    bus.mmcm_locked = 1'b0;
    step(1);
    chk("ll_bufg_s0", 32'(bus.bufg_s0), 1);
    chk("ll_bufg_s1", 32'(bus.bufg_s1), 0);
    chk("ll_pclk_sel", 32'(bus.pclk_sel), 0);
    chk("ll_no_done", 32'(done_seen), 4);
    bus.mmcm_locked = 1'b1;
    step(1);
    chk("ll_requal_busy", 32'(bus.busy), 1);
    step(3);
    chk("ll_requal_e12_s0", 32'(bus.bufg_s0), 1);
    step(1);
    chk("ll_requal_e13_gap", 32'({bus.bufg_s0, bus.bufg_s1}), 0);
    step(2);
    chk("ll_relock_s1", 32'(bus.bufg_s1), 1);
    chk("ll_relock_done", 32'(bus.switch_done), 1);
    chk("ll_relock_count", 32'(bus.switch_count), cexp(5));
    step(1);

    // Async reset while in QUAL, checked before the next clock edge
    bus.lane_sel_in = 8'h00;
    step(4);
    chk("ar_in_qual", 32'(bus.busy), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_pclk_sel", 32'(bus.pclk_sel), 0);
    chk("ar_bufg", 32'({bus.bufg_s0, bus.bufg_s1}), 2);
    chk("ar_busy", 32'(bus.busy), 0);
    chk("ar_count", 32'(bus.switch_count), 0);
    chk("ar_mismatch_err", 32'(bus.mismatch_err), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pcie_pclk_rate_ctrl.md
# pcie_pclk_rate_ctrl

Parametrised PIPE clock-rate controller for the 7-series PCIe integration. Each lane requests a PIPE pclk rate. The block synchronises these per-lane requests and considers only the lanes in the active-lane mask. It qualifies a rate change over a stability window and then drives a BUFGCTRL 125/250 MHz mux with a break-before-make gap. It also forces Gen1 whenever the MMCM is unlocked and reports switch events and lane disagreement.

## Interface
Parameters:
- LANES, 8, number of PIPE lanes (1..16)
- SYNC_STAGES, 2, synchroniser depth for lane_sel_in (>=2)
- STABLE_CYCLES, 16, cycles the masked request must hold before switching (>=1)
- GAP_CYCLES, 4, cycles both mux selects are held low during a switch (>=1)
- MISMATCH_CYCLES, 1024, consecutive disagreement cycles before mismatch_err is set

Ports (one clock; reset is asynchronous, active-low):
- sys_clk, in, 1, free-running stable clock (MMCM 125 MHz output, never the muxed pclk)
- sys_reset_n, in, 1, asynchronous active-low reset
- lane_sel_in, in, LANES, per-lane rate request (1 = 250 MHz), asynchronous
- lane_mask, in, LANES, active lanes (negotiated width), sys_clk domain, quasi-static
- mmcm_locked, in, 1, MMCM lock status
- mismatch_clr, in, 1, clears mismatch_err
- pclk_sel, out, 1, current committed rate
- bufg_s0, out, 1, BUFGCTRL S0 (125 MHz leg)
- bufg_s1, out, 1, BUFGCTRL S1 (250 MHz leg)
- busy, out, 1, high in QUAL or GAP
- switch_done, out, 1, one-cycle pulse when a new rate is committed
- switch_count, out, 16, saturating count of committed switches
- mismatch_err, out, 1, sticky lane-disagreement flag

## Operation
- lane_sel_in passes through SYNC_STAGES flops (ASYNC_REG). Call the last stage s.
- all_hi = &(s | ~lane_mask); all_lo = &(~s | ~lane_mask); mixed = lane_mask != 0 and neither all_hi nor all_lo.
- target_valid = (lane_mask != 0) && (all_hi || all_lo); target = all_hi.
- When lane_mask == 0, there is no request and the rate holds.
- FSM states: STEADY, QUAL, GAP. Counter cnt is 16 bits wide.
  - STEADY: if mmcm_locked && target_valid && target != pclk_sel, go to QUAL with cnt = 0.
  - QUAL: if !target_valid or target == pclk_sel, go to STEADY (abort; outputs unchanged). Else if cnt == STABLE_CYCLES-1, go to GAP: latch new_sel = target, set bufg_s0 = bufg_s1 = 0, cnt = 0. Else cnt++.
  - GAP: request changes are ignored. When cnt == GAP_CYCLES-1, go to STEADY: pclk_sel = new_sel, bufg_s0 = ~new_sel, bufg_s1 = new_sel, pulse switch_done, and increment switch_count (saturating at 0xFFFF). Else cnt++.
- mmcm_locked low has priority in every state and overrides all other transitions. It forces STEADY, pclk_sel = 0, bufg_s0 = 1, bufg_s1 = 0, with no switch_done and no count.
- Outside GAP, exactly one of bufg_s0/bufg_s1 is high. Both are never high at the same time.
- Mismatch: mm_cnt increments each cycle mixed is true and resets to 0 otherwise.
  - mismatch_err sets when mm_cnt reaches MISMATCH_CYCLES-1 while mixed.
  - mismatch_clr clears it. If set and clear happen together, set wins.

## Timing
- All outputs are registered.
- Reset values: pclk_sel = 0, bufg_s0 = 1, bufg_s1 = 0, busy = 0, switch_done = 0, switch_count = 0, mismatch_err = 0, state = STEADY, synchroniser flops = 0.
- Latency: an input change at lanes reaches s after SYNC_STAGES edges.
  - QUAL is entered 1 edge later.
  - bufg_s0/bufg_s1 fall STABLE_CYCLES edges after QUAL entry.
  - The new select rises GAP_CYCLES edges after that, in the same cycle as the switch_done pulse.
- Reset mid-GAP immediately restores the reset values asynchronously.
- A lane_mask change is evaluated in the same cycle; it may abort QUAL.

## Configuration
- PCLK_RATE_STATS_EN defined: switch_count and the mismatch logic (mm_cnt, mismatch_err, mismatch_clr) are built.
- PCLK_RATE_STATS_EN undefined: switch_count ties to 0, mismatch_err ties to 0, and mismatch_clr is ignored. Switching behaviour is identical either way.

## Test plan
Bench parameters: LANES=8, SYNC_STAGES=2, STABLE_CYCLES=4, GAP_CYCLES=2, MISMATCH_CYCLES=8.
- Upswitch: lane_mask=0xFF, mmcm_locked=1, lane_sel_in 0x00->0xFF at edge 0.
  - bufg_s0 falls at edge 7; bufg_s1 rises at edge 9 with a switch_done pulse; pclk_sel=1; switch_count=1.
- Masked width: lane_mask=0x0F, lane_sel_in=0x0F (lanes 4-7 low).
  - Switch to 250 MHz completes; lanes 4-7 are ignored.
- Glitch reject: lane_sel_in=0xFF for 3 cycles (after sync), then back to 0x00.
  - QUAL aborts; bufg_s0 stays 1; no switch_done; switch_count=0.
- Mismatch: lane_mask=0xFF, lane_sel_in=0xF0 held.
  - mismatch_err=1 after 8 mixed cycles; pclk_sel stays unchanged; mismatch_clr pulse clears it only once the lanes agree.
- Lock loss: mmcm_locked drops during GAP of an upswitch.
  - Next edge: bufg_s0=1, bufg_s1=0, pclk_sel=0, no switch_done. On relock with lanes still 0xFF, a fresh qualification is re-run.
- Async reset mid-operation: sys_reset_n asserted in QUAL.
  - All outputs take their reset values without any sys_clk edge.
